// File: rtl/pixel_write_buffer.sv
// Buffers pixel writes from the drawing FSMs and drains them into the framebuffer
// write port whenever the display side grants access.
module pixel_write_buffer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned H_RES = 320,
    parameter int unsigned V_RES = 240
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      draw_en,
    input  logic [8:0]                x,
    input  logic [7:0]                y,
    input  logic [2:0]                color,
    input  logic                      wr_allow,
    input  logic                      clear_flags,
    output logic                      fb_we,
    output logic [16:0]               fb_addr,
    output logic [2:0]                fb_data,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      full,
    output logic                      empty,
    output logic                      overflow,
    output logic                      range_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [19:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          range_err_q, range_err_d;
    logic          fb_we_q;
    logic [16:0]   fb_addr_q;
    logic [2:0]    fb_data_q;

    logic          in_range;
    logic          push;
    logic          pop;
    logic [16:0]   addr;
    logic [19:0]   head;

    assign in_range = (32'(x) < H_RES) && (32'(y) < V_RES);
    // 17-bit product so the bottom-right pixel address is not truncated
    assign addr     = 17'(y) * 17'(H_RES) + 17'(x);
    assign empty    = (level_q == '0);
    assign full     = (level_q == LW'(DEPTH));
    assign pop      = !empty && wr_allow;
    assign push     = draw_en && in_range && (!full || pop);
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q && !clear_flags;
        range_err_d = range_err_q && !clear_flags;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end

        // A fresh error in the clearing cycle keeps the flag set
        if (draw_en && !in_range) begin
            range_err_d = 1'b1;
        end
        if (draw_en && in_range && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            range_err_q <= 1'b0;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= '0;
            fb_data_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            range_err_q <= range_err_d;
            fb_we_q     <= pop;
            if (pop) begin
                fb_addr_q <= head[19:3];
                fb_data_q <= head[2:0];
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and level
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {addr, color};
        end
    end

    assign fb_we     = fb_we_q;
    assign fb_addr   = fb_addr_q;
    assign fb_data   = fb_data_q;
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign range_err = range_err_q;

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Directed bench for pixel_write_buffer: single pixel, corners, range reject,
// fill/overflow/drain, full push+pop and asynchronous reset.
module tb_pixel_write_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        draw_en;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  color;
    logic        wr_allow;
    logic        clear_flags;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [2:0]  fb_data;
    logic [4:0]  level;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        range_err;

    int checks = 0;
    int errors = 0;

    pixel_write_buffer #(
        .DEPTH(16),
        .H_RES(320),
        .V_RES(240)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .draw_en    (draw_en),
        .x          (x),
        .y          (y),
        .color      (color),
        .wr_allow   (wr_allow),
        .clear_flags(clear_flags),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .level      (level),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .range_err  (range_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pix(input int px, input int py, input int pc);
        draw_en = 1'b1;
        x       = 9'(px);
        y       = 8'(py);
        color   = 3'(pc);
    endtask

    initial begin
        reset       = 1'b1;
        draw_en     = 1'b0;
        x           = '0;
        y           = '0;
        color       = '0;
        wr_allow    = 1'b0;
        clear_flags = 1'b0;
        #2;
        chk("rst_fb_we", 32'(fb_we), 0);
        chk("rst_fb_addr", 32'(fb_addr), 0);
        chk("rst_fb_data", 32'(fb_data), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_range_err", 32'(range_err), 0);
        step();
        step();
        reset = 1'b0;

        // Single pixel (5,2) -> 2*320+5 = 645
        wr_allow = 1'b1;
        pix(5, 2, 5);
        step();
        draw_en = 1'b0;
        chk("single_no_bypass", 32'(fb_we), 0);
        chk("single_level", 32'(level), 1);
        step();
        chk("single_we", 32'(fb_we), 1);
        chk("single_addr", 32'(fb_addr), 645);
        chk("single_data", 32'(fb_data), 5);
        chk("single_empty", 32'(empty), 1);
        step();
        chk("single_we_once", 32'(fb_we), 0);
        chk("single_addr_hold", 32'(fb_addr), 645);

        // Corners back to back
        pix(0, 0, 1);
        step();
        pix(319, 239, 6);
        step();
        draw_en = 1'b0;
        chk("corner0_we", 32'(fb_we), 1);
        chk("corner0_addr", 32'(fb_addr), 0);
        chk("corner0_data", 32'(fb_data), 1);
        step();
        chk("corner1_we", 32'(fb_we), 1);
        chk("corner1_addr", 32'(fb_addr), 76799);
        chk("corner1_data", 32'(fb_data), 6);
        step();

        // Range reject on X, then clear, then reject on Y
        pix(320, 0, 2);
        step();
        draw_en = 1'b0;
        chk("range_flag", 32'(range_err), 1);
        chk("range_level", 32'(level), 0);
        step();
        chk("range_no_we", 32'(fb_we), 0);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        chk("range_cleared", 32'(range_err), 0);
        pix(0, 240, 2);
        step();
        draw_en = 1'b0;
        chk("range_y_flag", 32'(range_err), 1);
        chk("range_y_level", 32'(level), 0);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;

        // Stall and fill
        wr_allow = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pix(i, 0, i % 8);
            step();
        end
        chk("fill_level", 32'(level), 16);
        chk("fill_full", 32'(full), 1);
        chk("fill_overflow_clear", 32'(overflow), 0);
        pix(16, 0, 0);
        step();
        draw_en = 1'b0;
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_level", 32'(level), 16);
        wr_allow = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("drain_we", 32'(fb_we), 1);
            chk("drain_addr", 32'(fb_addr), 32'(i));
        end
        chk("drain_empty", 32'(empty), 1);
        step();
        chk("drain_stop", 32'(fb_we), 0);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        chk("ovf_cleared", 32'(overflow), 0);

        // Full FIFO accepts a pixel in the same cycle it pops one
        wr_allow = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pix(20 + i, 0, 3);
            step();
        end
        draw_en = 1'b0;
        chk("pp_full", 32'(full), 1);
        wr_allow = 1'b1;
        pix(99, 0, 7);
        step();
        draw_en = 1'b0;
        chk("pp_no_overflow", 32'(overflow), 0);
        chk("pp_level", 32'(level), 16);
        chk("pp_first_addr", 32'(fb_addr), 20);
        for (int k = 0; k < 16; k++) begin
            step();
            chk("pp_we", 32'(fb_we), 1);
            chk("pp_addr", 32'(fb_addr), (k < 15) ? 32'(21 + k) : 32'd99);
        end
        chk("pp_empty", 32'(empty), 1);
        step();

        // Asynchronous reset with level 8 and a write in flight
        wr_allow = 1'b0;
        for (int i = 0; i < 9; i++) begin
            pix(i, 1, 4);
            step();
        end
        draw_en  = 1'b0;
        wr_allow = 1'b1;
        step();
        chk("ar_pre_we", 32'(fb_we), 1);
        chk("ar_pre_level", 32'(level), 8);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_we", 32'(fb_we), 0);
        chk("ar_level", 32'(level), 0);
        chk("ar_empty", 32'(empty), 1);
        chk("ar_addr", 32'(fb_addr), 0);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ar_no_stale", 32'(fb_we), 0);
        end
        chk("ar_level_after", 32'(level), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
